// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared piece and scheduler state types
package tetris_pkg;

    typedef enum logic [2:0] {
        I    = 3'd0,
        O    = 3'd1,
        T    = 3'd2,
        S    = 3'd3,
        Z    = 3'd4,
        J    = 3'd5,
        L    = 3'd6,
        NONE = 3'd7
    } piece_t;

    localparam piece_t PIECE_NONE = NONE;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/piece_scheduler_if.sv
// rtl/piece_scheduler_if.sv - generator handshake and controller queue signals
interface piece_scheduler_if #(
    parameter int DEPTH = 3
);
    logic                   GEN_START;
    logic                   GEN_DONE;
    logic [2:0]             GEN_PIECE;
    logic                   POP;
    logic                   FLUSH;
    logic                   PIECE_VALID;
    logic [2:0]             PIECE_OUT;
    logic [3*DEPTH-1:0]     PREVIEW;
    logic [2:0]             COUNT;
    logic                   FULL;

    modport master (
        output GEN_START, PIECE_VALID, PIECE_OUT, PREVIEW, COUNT, FULL,
        input  GEN_DONE, GEN_PIECE, POP, FLUSH
    );

    modport slave (
        input  GEN_START, PIECE_VALID, PIECE_OUT, PREVIEW, COUNT, FULL,
        output GEN_DONE, GEN_PIECE, POP, FLUSH
    );
endinterface

// File: rtl/piece_fifo.sv
// rtl/piece_fifo.sv - shift-register piece queue, head at slot 0
module piece_fifo
    import tetris_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  piece_t             din,
    output logic [2:0]         count,
    output logic [3*DEPTH-1:0] preview
);

    piece_t     slot_q [DEPTH];
    piece_t     slot_d [DEPTH];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic [2:0] base;

    // pop shifts first, so a simultaneous push lands just behind the survivors
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        base    = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = PIECE_NONE;
            end
            count_d = 3'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slot_d[i] = slot_q[i+1];
                end
                slot_d[DEPTH-1] = PIECE_NONE;
                base = count_q - 3'd1;
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (3'(i) == base) begin
                        slot_d[i] = din;
                    end
                end
            end
            count_d = base + {2'b00, push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= PIECE_NONE;
            end
            count_q <= 3'd0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        preview = '0;
        for (int i = 0; i < DEPTH; i++) begin
            preview[3*i +: 3] = slot_q[i];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/piece_scheduler.sv
// rtl/piece_scheduler.sv - generator START/DONE sequencer with anti-repeat preview queue
module piece_scheduler
    import tetris_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int NO_REPEAT = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    piece_scheduler_if.master  bus
);

    sched_state_t state_q, state_d;
    piece_t       last_piece_q, last_piece_d;
    logic         reroll_used_q, reroll_used_d;

    logic [2:0]   count;
    logic [3*DEPTH-1:0] preview;
    logic         pop_eff;
    logic         push;
    logic [2:0]   avail;
    piece_t       gen_piece;

    assign gen_piece = piece_t'(bus.GEN_PIECE);
    assign pop_eff   = bus.POP & (count != 3'd0);
    assign avail     = count - {2'b00, pop_eff};

    always_comb begin
        state_d       = state_q;
        last_piece_d  = last_piece_q;
        reroll_used_d = reroll_used_q;
        push          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (avail < 3'(DEPTH)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.GEN_DONE) begin
                    state_d = S_RELEASE;
                    // discarded samples simply fall back through S_IDLE for a fresh request
                    if (bus.FLUSH || gen_piece == PIECE_NONE) begin
                        push = 1'b0;
                    end else if (NO_REPEAT != 0 && gen_piece == last_piece_q && !reroll_used_q) begin
                        reroll_used_d = 1'b1;
                    end else begin
                        push          = 1'b1;
                        last_piece_d  = gen_piece;
                        reroll_used_d = 1'b0;
                    end
                end
            end
            S_RELEASE: begin
                if (!bus.GEN_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.FLUSH) begin
            last_piece_d  = PIECE_NONE;
            reroll_used_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            last_piece_q  <= PIECE_NONE;
            reroll_used_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_piece_q  <= last_piece_d;
            reroll_used_q <= reroll_used_d;
        end
    end

    piece_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push    (push),
        .pop     (pop_eff),
        .flush   (bus.FLUSH),
        .din     (gen_piece),
        .count   (count),
        .preview (preview)
    );

    assign bus.GEN_START   = (state_q == S_REQ);
    assign bus.COUNT       = count;
    assign bus.PREVIEW     = preview;
    assign bus.PIECE_OUT   = preview[2:0];
    assign bus.PIECE_VALID = (count != 3'd0);
    assign bus.FULL        = (count == 3'(DEPTH));

`ifndef SYNTHESIS
    push_never_overflows: assert property (@(posedge CLK) disable iff (!RESET_N)
        push |-> ((count < 3'(DEPTH)) || pop_eff));
`endif

endmodule

// File: tb/tb_piece_scheduler.sv
// tb/tb_piece_scheduler.sv - directed bench with a scripted piece generator
module tb_piece_scheduler;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [2:0] gen_q [$];
    int   gen_wait = 0;
    int   lo_bad;

    piece_scheduler_if #(.DEPTH(3)) bus ();

    piece_scheduler #(
        .DEPTH     (3),
        .NO_REPEAT (1)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_count(input logic [2:0] n);
        for (int i = 0; i < 200; i++) begin
            if (bus.COUNT == n) break;
            @(negedge CLK);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (bus.GEN_DONE) break;
            @(negedge CLK);
        end
    endtask

    task automatic wait_gen_empty();
        for (int i = 0; i < 200; i++) begin
            if (gen_q.size() == 0) break;
            @(negedge CLK);
        end
    endtask

    task automatic pop_once();
        bus.POP = 1'b1;
        @(negedge CLK);
        bus.POP = 1'b0;
    endtask

    // generator: DONE two cycles after START is seen, held until START drops
    initial begin
        bus.GEN_DONE  = 1'b0;
        bus.GEN_PIECE = 3'd7;
        forever begin
            @(posedge CLK);
            #2;
            if (!RESET_N) begin
                bus.GEN_DONE  = 1'b0;
                bus.GEN_PIECE = 3'd7;
                gen_wait      = 0;
            end else if (bus.GEN_DONE) begin
                if (!bus.GEN_START) begin
                    bus.GEN_DONE  = 1'b0;
                    bus.GEN_PIECE = 3'd7;
                end
            end else if (bus.GEN_START) begin
                if (gen_wait < 2) gen_wait++;
                if (gen_wait >= 2 && gen_q.size() > 0) begin
                    bus.GEN_DONE  = 1'b1;
                    bus.GEN_PIECE = gen_q.pop_front();
                    gen_wait      = 0;
                end
            end
        end
    end

    initial begin
        bus.POP   = 1'b0;
        bus.FLUSH = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_count", bus.COUNT, 3'd0);
        check("rst_valid", bus.PIECE_VALID, 1'b0);
        check("rst_out", bus.PIECE_OUT, 3'd7);
        check("rst_preview", bus.PREVIEW, 9'o777);
        check("rst_full", bus.FULL, 1'b0);
        check("rst_start", bus.GEN_START, 1'b0);

        gen_q = '{3'd2, 3'd5, 3'd1};
        RESET_N = 1'b1;
        wait_count(3'd3);
        check("fill_count", bus.COUNT, 3'd3);
        check("fill_full", bus.FULL, 1'b1);
        check("fill_head", bus.PIECE_OUT, 3'd2);
        check("fill_preview", bus.PREVIEW, 9'o152);
        lo_bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (bus.GEN_START) lo_bad++;
        end
        check("full_no_start", lo_bad, 0);

        gen_q.push_back(3'd4);
        pop_once();
        check("pop_head", bus.PIECE_OUT, 3'd5);
        check("pop_count", bus.COUNT, 3'd2);
        check("pop_refill_start", bus.GEN_START, 1'b1);
        wait_count(3'd3);
        check("refill_preview", bus.PREVIEW, 9'o415);

        gen_q = '{3'd4, 3'd4};
        pop_once();
        wait_count(3'd3);
        check("reroll_preview", bus.PREVIEW, 9'o441);
        check("reroll_used_both", gen_q.size(), 0);

        gen_q = '{3'd4, 3'd3};
        pop_once();
        wait_count(3'd3);
        check("reroll_43_preview", bus.PREVIEW, 9'o344);
        check("reroll_43_used", gen_q.size(), 0);

        gen_q = '{3'd7};
        pop_once();
        wait_gen_empty();
        repeat (8) @(negedge CLK);
        check("none_count", bus.COUNT, 3'd2);
        check("none_rerequest", bus.GEN_START, 1'b1);
        gen_q.push_back(3'd6);
        wait_count(3'd3);
        check("none_preview", bus.PREVIEW, 9'o634);

        pop_once();
        check("pp_pre_count", bus.COUNT, 3'd2);
        gen_q.push_back(3'd1);
        wait_done();
        bus.POP = 1'b1;
        @(negedge CLK);
        bus.POP = 1'b0;
        check("pp_count", bus.COUNT, 3'd2);
        check("pp_head", bus.PIECE_OUT, 3'd6);
        check("pp_preview", bus.PREVIEW, 9'o716);

        repeat (4) @(negedge CLK);
        gen_q.push_back(3'd2);
        wait_done();
        bus.FLUSH = 1'b1;
        @(negedge CLK);
        bus.FLUSH = 1'b0;
        check("flush_count", bus.COUNT, 3'd0);
        check("flush_valid", bus.PIECE_VALID, 1'b0);
        check("flush_out", bus.PIECE_OUT, 3'd7);
        check("flush_preview", bus.PREVIEW, 9'o777);
        check("flush_start_drop", bus.GEN_START, 1'b0);
        pop_once();
        check("pop_empty_count", bus.COUNT, 3'd0);
        check("pop_empty_out", bus.PIECE_OUT, 3'd7);
        gen_q = '{3'd3, 3'd5, 3'd0};
        wait_count(3'd3);
        check("resume_preview", bus.PREVIEW, 9'o053);
        check("resume_full", bus.FULL, 1'b1);

        pop_once();
        for (int i = 0; i < 50; i++) begin
            if (bus.GEN_START) break;
            @(negedge CLK);
        end
        check("mid_req_start", bus.GEN_START, 1'b1);
        #1 RESET_N = 1'b0;
        #1;
        check("arst_start", bus.GEN_START, 1'b0);
        check("arst_count", bus.COUNT, 3'd0);
        check("arst_valid", bus.PIECE_VALID, 1'b0);
        check("arst_out", bus.PIECE_OUT, 3'd7);
        check("arst_preview", bus.PREVIEW, 9'o777);
        check("arst_full", bus.FULL, 1'b0);
        repeat (2) @(negedge CLK);
        gen_q = '{3'd6};
        RESET_N = 1'b1;
        wait_count(3'd1);
        check("post_rst_head", bus.PIECE_OUT, 3'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
